// File: rtl/csr_mcore_if.sv
// Execute-stage <-> machine-mode CSR unit bundle: CSR access, trap inputs, interrupt levels, redirect outputs.
// The stage drives requests (master); csr_mcore answers combinationally (slave).
interface csr_mcore_if #(parameter int XLEN = 64);
  logic            inst_valid;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_src;
  logic [XLEN-1:0] inst_pc;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic            inst_mret;
  logic            irq_mtip;
  logic            irq_msip;
  logic            irq_meip;
  logic [XLEN-1:0] csr_rdata;
  logic            trap_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output inst_valid, csr_op, csr_addr, csr_src, inst_pc, exc_valid, exc_cause, inst_mret,
           irq_mtip, irq_msip, irq_meip,
    input  csr_rdata, trap_valid, redirect_valid, redirect_pc
  );
  modport slave (
    input  inst_valid, csr_op, csr_addr, csr_src, inst_pc, exc_valid, exc_cause, inst_mret,
           irq_mtip, irq_msip, irq_meip,
    output csr_rdata, trap_valid, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_mcore.sv
// Machine-mode CSR file with prioritised trap entry and mret; rdata/trap/redirect are same-cycle combinational.
// State commits at the next clk edge; never stalls the stage (no backpressure).
module csr_mcore #(
  parameter int              XLEN     = 64,
  parameter int              HART_ID  = 0,
  parameter bit              VECTORED = 1'b1,
  parameter logic [XLEN-1:0] MISA_VAL = {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-14){1'b0}}, 12'h100}
) (
  input  logic         clk,
  input  logic         rst,
  csr_mcore_if.slave   bus
);
  localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305, A_MCNTINH  = 12'h320, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341, A_MCAUSE   = 12'h342, A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11, A_MARCHID  = 12'hF12, A_MIMPID   = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [XLEN-1:0] LOW2 = XLEN'(3);

  // interrupt bit vectors are ordered {MEI, MTI, MSI}
  logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [2:0]      ie_q, ie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, mscratch_q, mscratch_d;
  logic            cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [2:0]      irq_meta_q, irq_sync_q;

  logic [XLEN-1:0] rd_val, wdata, vec_off;
  logic            impl, wants_write, illegal, wr_en;
  logic [2:0]      irq_pend;
  logic            irq_take, exc_take, ill_take, trap, mret_take;
  logic [3:0]      irq_code, trap_code;
  logic [1:0]      mode_new;

  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS:   rd_val = XLEN'({2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0});
      A_MISA:      rd_val = MISA_VAL;
      A_MIE:       rd_val = XLEN'({ie_q[2], 3'b0, ie_q[1], 3'b0, ie_q[0], 3'b0});
      A_MTVEC:     rd_val = mtvec_q;
      A_MCNTINH:   rd_val = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
      A_MSCRATCH:  rd_val = mscratch_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = mcause_q;
      A_MIP:       rd_val = XLEN'({irq_sync_q[2], 3'b0, irq_sync_q[1], 3'b0, irq_sync_q[0], 3'b0});
      A_MCYCLE:    rd_val = mcycle_q[XLEN-1:0];
      A_MINSTRET:  rd_val = minstret_q[XLEN-1:0];
      A_MCYCLEH:   if (XLEN == 32) rd_val = XLEN'(mcycle_q[63:32]); else impl = 1'b0;
      A_MINSTRETH: if (XLEN == 32) rd_val = XLEN'(minstret_q[63:32]); else impl = 1'b0;
      A_MVENDOR, A_MIMPID: rd_val = '0;
      A_MARCHID:   rd_val = XLEN'(1);
      A_MHARTID:   rd_val = XLEN'(HART_ID);
      default:     impl = 1'b0;
    endcase
  end

  // RS/RC with a zero source is a pure read, so it is legal even on read-only space
  assign wants_write = (bus.csr_op == 2'b01) || (bus.csr_op[1] && (|bus.csr_src));
  assign illegal     = bus.inst_valid && (bus.csr_op != 2'b00) &&
                       (!impl || ((bus.csr_addr[11:10] == 2'b11) && wants_write));

  always_comb begin
    case (bus.csr_op)
      2'b01:   wdata = bus.csr_src;
      2'b10:   wdata = rd_val | bus.csr_src;
      2'b11:   wdata = rd_val & ~bus.csr_src;
      default: wdata = rd_val;
    endcase
  end

  assign irq_pend  = irq_sync_q & ie_q;
  assign irq_take  = bus.inst_valid && st_mie_q && (|irq_pend);
  assign irq_code  = irq_pend[2] ? 4'd11 : (irq_pend[0] ? 4'd3 : 4'd7);
  assign exc_take  = bus.inst_valid && !irq_take && bus.exc_valid;
  assign ill_take  = bus.inst_valid && !irq_take && !bus.exc_valid && illegal;
  assign trap      = irq_take || exc_take || ill_take;
  assign trap_code = irq_take ? irq_code : (exc_take ? bus.exc_cause : 4'd2);
  assign mret_take = bus.inst_valid && bus.inst_mret && !trap;
  assign wr_en     = bus.inst_valid && !trap && wants_write;
  assign mode_new  = (VECTORED && (wdata[1:0] == 2'b01)) ? 2'b01 : 2'b00;
  assign vec_off   = (irq_take && (mtvec_q[1:0] == 2'b01)) ? XLEN'({irq_code, 2'b00}) : '0;

  assign bus.csr_rdata      = illegal ? '0 : rd_val;
  assign bus.trap_valid     = trap;
  assign bus.redirect_valid = trap || mret_take;
  assign bus.redirect_pc    = trap ? ((mtvec_q & ~LOW2) + vec_off) : mepc_q;

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    ie_d       = ie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    cy_inh_d   = cy_inh_q;
    ir_inh_d   = ir_inh_q;
    mcycle_d   = cy_inh_q ? mcycle_q : mcycle_q + 64'd1;
    minstret_d = (bus.inst_valid && !trap && !ir_inh_q) ? minstret_q + 64'd1 : minstret_q;
    // counter writes restart from the held value so the dropped increment cannot carry
    if (wr_en) begin
      case (bus.csr_addr)
        A_MSTATUS:  begin st_mie_d = wdata[3]; st_mpie_d = wdata[7]; end
        A_MIE:      ie_d = {wdata[11], wdata[7], wdata[3]};
        A_MTVEC:    mtvec_d = {wdata[XLEN-1:2], mode_new};
        A_MCNTINH:  begin cy_inh_d = wdata[0]; ir_inh_d = wdata[2]; end
        A_MSCRATCH: mscratch_d = wdata;
        A_MEPC:     mepc_d = wdata & ~LOW2;
        A_MCAUSE:   mcause_d = wdata;
        A_MCYCLE: begin
          mcycle_d = mcycle_q;
          if (XLEN == 32) mcycle_d[31:0] = wdata[31:0]; else mcycle_d = 64'(wdata);
        end
        A_MINSTRET: begin
          minstret_d = minstret_q;
          if (XLEN == 32) minstret_d[31:0] = wdata[31:0]; else minstret_d = 64'(wdata);
        end
        A_MCYCLEH:   if (XLEN == 32) begin mcycle_d = mcycle_q; mcycle_d[63:32] = wdata[31:0]; end
        A_MINSTRETH: if (XLEN == 32) begin minstret_d = minstret_q; minstret_d[63:32] = wdata[31:0]; end
        default: ;
      endcase
    end
    if (mret_take) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end
    if (trap) begin
      mepc_d    = bus.inst_pc & ~LOW2;
      mcause_d  = {irq_take, {(XLEN-5){1'b0}}, trap_code};
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      ie_q       <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      cy_inh_q   <= 1'b0;
      ir_inh_q   <= 1'b0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      ie_q       <= ie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      cy_inh_q   <= cy_inh_d;
      ir_inh_q   <= ir_inh_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      irq_meta_q <= {bus.irq_meip, bus.irq_mtip, bus.irq_msip};
      irq_sync_q <= irq_meta_q;
    end
  end
endmodule

// File: tb/tb_csr_mcore.sv
// Directed bench for csr_mcore: a 64-bit hart (HART_ID=3) and a 32-bit hart side by side.
// Inputs change 1 time unit after posedge; combinational outputs are sampled before the next edge.
module tb_csr_mcore;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_mcore_if #(.XLEN(64)) bus64 ();
  csr_mcore_if #(.XLEN(32)) bus32 ();

  csr_mcore #(.XLEN(64), .HART_ID(3), .VECTORED(1'b1)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
  csr_mcore #(.XLEN(32), .HART_ID(0), .VECTORED(1'b1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] rd;
  logic [63:0] snap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus64.inst_valid = 1'b0; bus64.csr_op = 2'b00; bus64.csr_addr = '0; bus64.csr_src = '0;
    bus64.inst_pc = '0; bus64.exc_valid = 1'b0; bus64.exc_cause = '0; bus64.inst_mret = 1'b0;
    bus32.inst_valid = 1'b0; bus32.csr_op = 2'b00; bus32.csr_addr = '0; bus32.csr_src = '0;
    bus32.inst_pc = '0; bus32.exc_valid = 1'b0; bus32.exc_cause = '0; bus32.inst_mret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drv64(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [63:0] s,
                       input logic [63:0] pc, input logic ev, input logic [3:0] ec, input logic mr);
    bus64.inst_valid = v; bus64.csr_op = op; bus64.csr_addr = a; bus64.csr_src = s;
    bus64.inst_pc = pc; bus64.exc_valid = ev; bus64.exc_cause = ec; bus64.inst_mret = mr;
    #1;
  endtask

  task automatic drv32(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
    bus32.inst_valid = v; bus32.csr_op = op; bus32.csr_addr = a; bus32.csr_src = s;
    #1;
  endtask

  task automatic peek64(input logic [11:0] a, output logic [63:0] d);
    drv64(1'b0, 2'b00, a, '0, '0, 1'b0, 4'd0, 1'b0);
    d = bus64.csr_rdata;
  endtask

  task automatic peek32(input logic [11:0] a, output logic [63:0] d);
    drv32(1'b0, 2'b00, a, '0);
    d = 64'(bus32.csr_rdata);
  endtask

  initial begin
    rst = 1'b1;
    bus64.irq_mtip = 1'b0; bus64.irq_msip = 1'b0; bus64.irq_meip = 1'b0;
    bus32.irq_mtip = 1'b0; bus32.irq_msip = 1'b0; bus32.irq_meip = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    peek64(12'h300, rd); chk("rst_mstatus", rd, 64'h1800);
    chk("rst_trap", 64'(bus64.trap_valid), 64'd0);
    rst = 1'b0;
    peek64(12'hF14, rd); chk("mhartid", rd, 64'd3);
    peek64(12'hB00, rd); chk("mcycle0", rd, 64'd0);
    repeat (10) tick();
    peek64(12'hB00, rd); chk("mcycle10", rd, 64'd10);
    peek64(12'h301, rd); chk("misa64", rd, 64'h8000_0000_0000_0100);

    // vectored timer interrupt
    drv64(1'b1, 2'b01, 12'h305, 64'h8000_0001, 64'h100, 1'b0, 4'd0, 1'b0);
    chk("mtvec_old", bus64.csr_rdata, 64'd0);
    tick();
    drv64(1'b1, 2'b10, 12'h300, 64'h8, 64'h104, 1'b0, 4'd0, 1'b0);
    chk("mstatus_rs_old", bus64.csr_rdata, 64'h1800);
    tick();
    drv64(1'b1, 2'b10, 12'h304, 64'h80, 64'h108, 1'b0, 4'd0, 1'b0);
    tick();
    bus64.irq_mtip = 1'b1;
    drv64(1'b1, 2'b00, 12'h0, '0, 64'h1000, 1'b0, 4'd0, 1'b0);
    chk("mti_i1", 64'(bus64.trap_valid), 64'd0);
    tick();
    drv64(1'b1, 2'b00, 12'h0, '0, 64'h1004, 1'b0, 4'd0, 1'b0);
    chk("mti_i2", 64'(bus64.trap_valid), 64'd0);
    tick();
    drv64(1'b1, 2'b00, 12'h0, '0, 64'h1008, 1'b0, 4'd0, 1'b0);
    chk("mti_i3", 64'(bus64.trap_valid), 64'd1);
    chk("mti_redir_v", 64'(bus64.redirect_valid), 64'd1);
    chk("mti_redir_pc", bus64.redirect_pc, 64'h8000_001C);
    tick();
    bus64.irq_mtip = 1'b0;
    peek64(12'h342, rd); chk("mti_mcause", rd, 64'h8000_0000_0000_0007);
    peek64(12'h341, rd); chk("mti_mepc", rd, 64'h1008);
    peek64(12'h300, rd); chk("mti_mstatus", rd, 64'h1880);
    peek64(12'hB02, rd); chk("mti_minstret", rd, 64'd5);
    tick(); tick();

    // mret back, then MEI+MTI together with an exception
    drv64(1'b1, 2'b00, 12'h0, '0, 64'h8000_001C, 1'b0, 4'd0, 1'b1);
    chk("mret1_trap", 64'(bus64.trap_valid), 64'd0);
    chk("mret1_pc", bus64.redirect_pc, 64'h1008);
    tick();
    peek64(12'h300, rd); chk("mret1_mstatus", rd, 64'h1888);
    drv64(1'b1, 2'b10, 12'h304, 64'h800, 64'h100C, 1'b0, 4'd0, 1'b0);
    chk("mie_old", bus64.csr_rdata, 64'h80);
    tick();
    bus64.irq_meip = 1'b1; bus64.irq_mtip = 1'b1;
    tick(); tick();
    drv64(1'b1, 2'b01, 12'h340, 64'hDEAD, 64'h2002, 1'b1, 4'd11, 1'b0);
    chk("mei_trap", 64'(bus64.trap_valid), 64'd1);
    chk("mei_redir_pc", bus64.redirect_pc, 64'h8000_002C);
    tick();
    bus64.irq_meip = 1'b0; bus64.irq_mtip = 1'b0;
    peek64(12'h342, rd); chk("mei_mcause", rd, 64'h8000_0000_0000_000B);
    peek64(12'h340, rd); chk("mei_no_write", rd, 64'd0);
    peek64(12'hB02, rd); chk("mei_minstret", rd, 64'd7);
    peek64(12'h341, rd); chk("mei_mepc", rd, 64'h2000);
    tick(); tick();

    // ecall then mret
    drv64(1'b1, 2'b10, 12'h300, 64'h8, 64'h3000, 1'b0, 4'd0, 1'b0);
    chk("pre_ecall_mstatus", bus64.csr_rdata, 64'h1880);
    tick();
    drv64(1'b1, 2'b00, 12'h0, '0, 64'h3004, 1'b1, 4'd11, 1'b0);
    chk("ecall_trap", 64'(bus64.trap_valid), 64'd1);
    chk("ecall_pc", bus64.redirect_pc, 64'h8000_0000);
    tick();
    peek64(12'h342, rd); chk("ecall_mcause", rd, 64'd11);
    peek64(12'h300, rd); chk("ecall_mstatus", rd, 64'h1880);
    drv64(1'b1, 2'b00, 12'h0, '0, 64'h8000_0000, 1'b0, 4'd0, 1'b1);
    chk("mret2_v", 64'(bus64.redirect_valid), 64'd1);
    chk("mret2_pc", bus64.redirect_pc, 64'h3004);
    tick();
    peek64(12'h300, rd); chk("mret2_mstatus", rd, 64'h1888);

    // illegal accesses
    drv64(1'b1, 2'b01, 12'hF11, '0, 64'h4000, 1'b0, 4'd0, 1'b0);
    chk("ro_rw_trap", 64'(bus64.trap_valid), 64'd1);
    chk("ro_rw_rdata", bus64.csr_rdata, 64'd0);
    tick();
    peek64(12'h342, rd); chk("ro_rw_mcause", rd, 64'd2);
    drv64(1'b1, 2'b10, 12'hF12, '0, 64'h8000_0000, 1'b0, 4'd0, 1'b0);
    chk("ro_rs0_trap", 64'(bus64.trap_valid), 64'd0);
    chk("ro_rs0_rdata", bus64.csr_rdata, 64'd1);
    tick();
    drv64(1'b1, 2'b01, 12'h342, 64'h5, 64'h8000_0004, 1'b0, 4'd0, 1'b0);
    tick();
    drv64(1'b1, 2'b10, 12'h7C0, '0, 64'h8000_0008, 1'b0, 4'd0, 1'b0);
    chk("unimpl_trap", 64'(bus64.trap_valid), 64'd1);
    tick();
    peek64(12'h342, rd); chk("unimpl_mcause", rd, 64'd2);
    drv64(1'b1, 2'b10, 12'hB80, '0, 64'h8000_0000, 1'b0, 4'd0, 1'b0);
    chk("mcycleh64_trap", 64'(bus64.trap_valid), 64'd1);
    tick();
    drv64(1'b1, 2'b01, 12'h344, 64'hFFF, 64'h8000_0000, 1'b0, 4'd0, 1'b0);
    chk("mip_wr_legal", 64'(bus64.trap_valid), 64'd0);
    tick();
    peek64(12'h344, rd); chk("mip_ro", rd, 64'd0);

    // RW / RC on mscratch
    drv64(1'b1, 2'b01, 12'h340, 64'hF0F0, 64'h8000_0004, 1'b0, 4'd0, 1'b0);
    tick();
    drv64(1'b1, 2'b11, 12'h340, 64'h00F0, 64'h8000_0008, 1'b0, 4'd0, 1'b0);
    chk("rc_old", bus64.csr_rdata, 64'hF0F0);
    tick();
    peek64(12'h340, rd); chk("rc_new", rd, 64'hF000);

    // 32-bit hart: counter halves, WARL, inhibit
    peek32(12'h301, rd); chk("misa32", rd, 64'h4000_0100);
    drv32(1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    peek32(12'hB00, rd); chk("mcyc32_lo", rd, 64'hFFFF_FFFF);
    peek32(12'hB80, rd); chk("mcyc32_hi0", rd, 64'd0);
    tick();
    peek32(12'hB00, rd); chk("mcyc32_wrap", rd, 64'd0);
    peek32(12'hB80, rd); chk("mcyc32_hi1", rd, 64'd1);
    drv32(1'b1, 2'b01, 12'h305, 32'h1003);
    tick();
    peek32(12'h305, rd); chk("mtvec_warl", rd, 64'h1000);
    drv32(1'b1, 2'b01, 12'h341, 32'h1237);
    tick();
    peek32(12'h341, rd); chk("mepc_warl", rd, 64'h1234);
    drv32(1'b1, 2'b01, 12'hB02, 32'h50);
    tick();
    peek32(12'hB02, rd); chk("minstret_wr", rd, 64'h50);
    drv32(1'b1, 2'b00, 12'h0, '0);
    tick();
    peek32(12'hB02, rd); chk("minstret_inc", rd, 64'h51);
    drv32(1'b1, 2'b01, 12'h320, 32'hFFFF_FFFF);
    tick();
    peek32(12'h320, rd); chk("mcntinh_warl", rd, 64'd5);
    peek32(12'hB00, snap);
    drv32(1'b1, 2'b00, 12'h0, '0);
    tick();
    drv32(1'b1, 2'b00, 12'h0, '0);
    tick();
    tick();
    peek32(12'hB00, rd); chk("mcycle_frozen", rd, snap);
    peek32(12'hB02, rd); chk("minstret_frozen", rd, 64'h52);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
